// File: rtl/pipeline_stage_regs.sv
// Four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage hold/flush,
// upstream stall propagation, stall bubbles and saturating stall/bubble event counters.
module pipeline_stage_regs #(
    parameter int IF_ID_W  = 64,
    parameter int ID_EX_W  = 168,
    parameter int EX_MEM_W = 107,
    parameter int MEM_WB_W = 71,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IF_ID_W-1:0]  if_id_in,
    input  logic                if_valid,
    input  logic [ID_EX_W-1:0]  id_ex_in,
    input  logic [EX_MEM_W-1:0] ex_mem_in,
    input  logic [MEM_WB_W-1:0] mem_wb_in,
    input  logic [3:0]          hold,
    input  logic [3:0]          flush,
    input  logic                cnt_clr,
    output logic [IF_ID_W-1:0]  if_id_out,
    output logic [ID_EX_W-1:0]  id_ex_out,
    output logic [EX_MEM_W-1:0] ex_mem_out,
    output logic [MEM_WB_W-1:0] mem_wb_out,
    output logic [3:0]          valid_out,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] eh;         // effective hold, stall propagated upstream
    logic [3:0] valid_in;   // valid each register would load
    logic [3:0] stall_bub;  // bubble because the upstream register is frozen
    logic [3:0] zero;       // register is cleared this cycle
    logic [3:0] load;       // register takes its input this cycle
    logic       stall_any;
    logic       bubble_any;

    always_comb begin
        eh[3] = hold[3];
        for (int i = 2; i >= 0; i--) begin
            eh[i] = hold[i] | eh[i+1];
        end

        valid_in     = {valid_out[2:0], if_valid};
        stall_bub[0] = 1'b0;
        for (int i = 1; i < 4; i++) begin
            stall_bub[i] = eh[i-1] & ~eh[i] & ~flush[i];
        end

        zero       = flush | stall_bub;
        load       = ~flush & ~eh & ~stall_bub;
        stall_any  = |eh;
        // Only bubbles that displace a real instruction count as events.
        bubble_any = |(zero & (valid_out | valid_in));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, which the stall chain depends on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (zero[i]) begin
                    valid_out[i] <= 1'b0;
                end else if (load[i]) begin
                    valid_out[i] <= valid_in[i];
                end
            end
        end
    end

    // Payloads are gated by the incoming valid so invalid entries always read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_out <= '0;
        end else if (zero[0]) begin
            if_id_out <= '0;
        end else if (load[0]) begin
            if_id_out <= valid_in[0] ? if_id_in : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex_out <= '0;
        end else if (zero[1]) begin
            id_ex_out <= '0;
        end else if (load[1]) begin
            id_ex_out <= valid_in[1] ? id_ex_in : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_mem_out <= '0;
        end else if (zero[2]) begin
            ex_mem_out <= '0;
        end else if (load[2]) begin
            ex_mem_out <= valid_in[2] ? ex_mem_in : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb_out <= '0;
        end else if (zero[3]) begin
            mem_wb_out <= '0;
        end else if (load[3]) begin
            mem_wb_out <= valid_in[3] ? mem_wb_in : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_any && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bubble_any && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for pipeline_stage_regs: a vector table for flow, stall and flush
// behaviour plus hand-written sequences for counter saturation and async reset.
module tb_pipeline_stage_regs;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 168;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;
    localparam int CNT_W    = 4;
    localparam int NVEC     = 21;

    logic                clk = 1'b0;
    logic                reset;
    logic [IF_ID_W-1:0]  if_id_in;
    logic                if_valid;
    logic [ID_EX_W-1:0]  id_ex_in;
    logic [EX_MEM_W-1:0] ex_mem_in;
    logic [MEM_WB_W-1:0] mem_wb_in;
    logic [3:0]          hold;
    logic [3:0]          flush;
    logic                cnt_clr;
    logic [IF_ID_W-1:0]  if_id_out;
    logic [ID_EX_W-1:0]  id_ex_out;
    logic [EX_MEM_W-1:0] ex_mem_out;
    logic [MEM_WB_W-1:0] mem_wb_out;
    logic [3:0]          valid_out;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    bubble_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_stage_regs #(
        .IF_ID_W (IF_ID_W),
        .ID_EX_W (ID_EX_W),
        .EX_MEM_W(EX_MEM_W),
        .MEM_WB_W(MEM_WB_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_id_in  (if_id_in),
        .if_valid  (if_valid),
        .id_ex_in  (id_ex_in),
        .ex_mem_in (ex_mem_in),
        .mem_wb_in (mem_wb_in),
        .hold      (hold),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .if_id_out (if_id_out),
        .id_ex_out (id_ex_out),
        .ex_mem_out(ex_mem_out),
        .mem_wb_out(mem_wb_out),
        .valid_out (valid_out),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                ifv;
        logic [3:0]          hold;
        logic [3:0]          flush;
        logic                clr;
        logic [IF_ID_W-1:0]  i0;
        logic [ID_EX_W-1:0]  i1;
        logic [EX_MEM_W-1:0] i2;
        logic [MEM_WB_W-1:0] i3;
        logic [3:0]          ev;
        logic [IF_ID_W-1:0]  e0;
        logic [ID_EX_W-1:0]  e1;
        logic [EX_MEM_W-1:0] e2;
        logic [MEM_WB_W-1:0] e3;
        logic [CNT_W-1:0]    es;
        logic [CNT_W-1:0]    eb;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic ifv, input logic [3:0] h, input logic [3:0] f, input logic clr,
        input logic [IF_ID_W-1:0] i0, input logic [ID_EX_W-1:0] i1,
        input logic [EX_MEM_W-1:0] i2, input logic [MEM_WB_W-1:0] i3,
        input logic [3:0] ev, input logic [IF_ID_W-1:0] e0, input logic [ID_EX_W-1:0] e1,
        input logic [EX_MEM_W-1:0] e2, input logic [MEM_WB_W-1:0] e3,
        input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] eb);
        vec_t v;
        v.ifv = ifv; v.hold = h; v.flush = f; v.clr = clr;
        v.i0 = i0; v.i1 = i1; v.i2 = i2; v.i3 = i3;
        v.ev = ev; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.es = es; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [ID_EX_W-1:0] act,
                         input logic [ID_EX_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ev,
                             input logic [IF_ID_W-1:0] e0, input logic [ID_EX_W-1:0] e1,
                             input logic [EX_MEM_W-1:0] e2, input logic [MEM_WB_W-1:0] e3,
                             input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] eb);
        check({tag, " valid_out"},  ID_EX_W'(valid_out),  ID_EX_W'(ev));
        check({tag, " if_id_out"},  ID_EX_W'(if_id_out),  ID_EX_W'(e0));
        check({tag, " id_ex_out"},  id_ex_out,            e1);
        check({tag, " ex_mem_out"}, ID_EX_W'(ex_mem_out), ID_EX_W'(e2));
        check({tag, " mem_wb_out"}, ID_EX_W'(mem_wb_out), ID_EX_W'(e3));
        check({tag, " stall_cnt"},  ID_EX_W'(stall_cnt),  ID_EX_W'(es));
        check({tag, " bubble_cnt"}, ID_EX_W'(bubble_cnt), ID_EX_W'(eb));
    endtask

    initial begin
        // Flow, load-use stall, branch flush, flush-vs-hold, freeze and clear-with-hold.
        tbl[0]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0004_0000_0013, 168'hA5, 107'h111, 71'h222,
                     4'b0001, 64'h0000_0004_0000_0013, 168'h0, 107'h0, 71'h0, 4'd0, 4'd0);
        tbl[1]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0008_0000_0033, 168'hA5, 107'h333, 71'h444,
                     4'b0011, 64'h0000_0008_0000_0033, 168'hA5, 107'h0, 71'h0, 4'd0, 4'd0);
        tbl[2]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_000C_0000_0073, 168'hB6, 107'h555, 71'h666,
                     4'b0111, 64'h0000_000C_0000_0073, 168'hB6, 107'h555, 71'h0, 4'd0, 4'd0);
        tbl[3]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0010_0000_0093, 168'hC7, 107'h777, 71'h888,
                     4'b1111, 64'h0000_0010_0000_0093, 168'hC7, 107'h777, 71'h888, 4'd0, 4'd0);
        tbl[4]  = mk(1, 4'b0001, 4'b0000, 0, 64'h0000_0014_0000_00B3, 168'hD8, 107'h999, 71'hAAA,
                     4'b1101, 64'h0000_0010_0000_0093, 168'h0, 107'h999, 71'hAAA, 4'd1, 4'd1);
        tbl[5]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0018_0000_00D3, 168'hE9, 107'hBBB, 71'hCCC,
                     4'b1011, 64'h0000_0018_0000_00D3, 168'hE9, 107'h0, 71'hCCC, 4'd1, 4'd1);
        tbl[6]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_001C_0000_00F3, 168'hF0, 107'hDDD, 71'hEEE,
                     4'b0111, 64'h0000_001C_0000_00F3, 168'hF0, 107'hDDD, 71'h0, 4'd1, 4'd1);
        tbl[7]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0020_0000_0113, 168'h11, 107'h1F1, 71'h2F2,
                     4'b1111, 64'h0000_0020_0000_0113, 168'h11, 107'h1F1, 71'h2F2, 4'd1, 4'd1);
        tbl[8]  = mk(1, 4'b0000, 4'b0011, 0, 64'h0000_0024_0000_0133, 168'h22, 107'h3F3, 71'h4F4,
                     4'b1100, 64'h0, 168'h0, 107'h3F3, 71'h4F4, 4'd1, 4'd2);
        tbl[9]  = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0028_0000_0153, 168'h33, 107'h5F5, 71'h6F6,
                     4'b1001, 64'h0000_0028_0000_0153, 168'h0, 107'h0, 71'h6F6, 4'd1, 4'd2);
        tbl[10] = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_002C_0000_0173, 168'h44, 107'h7F7, 71'h8F8,
                     4'b0011, 64'h0000_002C_0000_0173, 168'h44, 107'h0, 71'h0, 4'd1, 4'd2);
        tbl[11] = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0030_0000_0193, 168'h55, 107'h9F9, 71'hAFA,
                     4'b0111, 64'h0000_0030_0000_0193, 168'h55, 107'h9F9, 71'h0, 4'd1, 4'd2);
        tbl[12] = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0034_0000_01B3, 168'h66, 107'hBFB, 71'hCFC,
                     4'b1111, 64'h0000_0034_0000_01B3, 168'h66, 107'hBFB, 71'hCFC, 4'd1, 4'd2);
        tbl[13] = mk(1, 4'b0100, 4'b0100, 0, 64'h0000_0038_0000_01D3, 168'h77, 107'hDFD, 71'hEFE,
                     4'b0011, 64'h0000_0034_0000_01B3, 168'h66, 107'h0, 71'h0, 4'd2, 4'd3);
        tbl[14] = mk(1, 4'b0100, 4'b0001, 0, 64'h0000_003C_0000_01F3, 168'h88, 107'h1E1, 71'h2E2,
                     4'b0010, 64'h0, 168'h66, 107'h0, 71'h0, 4'd3, 4'd4);
        tbl[15] = mk(1, 4'b1111, 4'b0000, 0, 64'h0000_0040_0000_0213, 168'h9A, 107'h3E3, 71'h4E4,
                     4'b0010, 64'h0, 168'h66, 107'h0, 71'h0, 4'd4, 4'd4);
        tbl[16] = mk(0, 4'b1000, 4'b0000, 0, 64'h0000_0044_0000_0233, 168'h99, 107'h515, 71'h616,
                     4'b0010, 64'h0, 168'h66, 107'h0, 71'h0, 4'd5, 4'd4);
        tbl[17] = mk(0, 4'b0000, 4'b0000, 0, 64'h0000_0048_0000_0253, 168'hAA, 107'h5E5, 71'h6E6,
                     4'b0100, 64'h0, 168'h0, 107'h5E5, 71'h0, 4'd5, 4'd4);
        tbl[18] = mk(0, 4'b0000, 4'b0000, 0, 64'h0000_004C_0000_0273, 168'hBB, 107'h7E7, 71'h8E8,
                     4'b1000, 64'h0, 168'h0, 107'h0, 71'h8E8, 4'd5, 4'd4);
        tbl[19] = mk(1, 4'b0010, 4'b0000, 1, 64'h0000_0050_0000_0293, 168'hCC, 107'h9E9, 71'hAEA,
                     4'b0000, 64'h0, 168'h0, 107'h0, 71'h0, 4'd0, 4'd0);
        tbl[20] = mk(1, 4'b0000, 4'b0000, 0, 64'h0000_0054_0000_02B3, 168'hDD, 107'hBEB, 71'hCEC,
                     4'b0001, 64'h0000_0054_0000_02B3, 168'h0, 107'h0, 71'h0, 4'd0, 4'd0);

        // Reset held low for two edges with nonzero inputs.
        reset     = 1'b0;
        if_valid  = 1'b1;
        if_id_in  = '1;
        id_ex_in  = '1;
        ex_mem_in = '1;
        mem_wb_in = '1;
        hold      = 4'b0000;
        flush     = 4'b0000;
        cnt_clr   = 1'b0;
        step();
        step();
        check_all("reset", 4'b0000, 64'h0, 168'h0, 107'h0, 71'h0, 4'd0, 4'd0);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            if_valid  = tbl[i].ifv;
            hold      = tbl[i].hold;
            flush     = tbl[i].flush;
            cnt_clr   = tbl[i].clr;
            if_id_in  = tbl[i].i0;
            id_ex_in  = tbl[i].i1;
            ex_mem_in = tbl[i].i2;
            mem_wb_in = tbl[i].i3;
            step();
            check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].e0, tbl[i].e1, tbl[i].e2,
                      tbl[i].e3, tbl[i].es, tbl[i].eb);
        end

        // Saturation: MEM/WB hold freezes the whole pipe for 20 cycles.
        cnt_clr = 1'b0;
        flush   = 4'b0000;
        hold    = 4'b1000;
        for (int i = 0; i < 20; i++) step();
        check_all("sat", 4'b0001, 64'h0000_0054_0000_02B3, 168'h0, 107'h0, 71'h0, 4'hF, 4'd0);

        cnt_clr = 1'b1;
        step();
        check("clr stall_cnt", ID_EX_W'(stall_cnt), ID_EX_W'(4'd0));
        cnt_clr = 1'b0;
        step();
        check("after clr stall_cnt", ID_EX_W'(stall_cnt), ID_EX_W'(4'd1));

        // Async reset asserted between edges during an all-ones hold.
        hold = 4'b1111;
        step();
        check("pre-reset stall_cnt", ID_EX_W'(stall_cnt), ID_EX_W'(4'd2));
        #2 reset = 1'b0;
        #1;
        check_all("async", 4'b0000, 64'h0, 168'h0, 107'h0, 71'h0, 4'd0, 4'd0);
        step();
        reset    = 1'b1;
        hold     = 4'b0000;
        if_valid = 1'b0;
        step();
        check_all("restart", 4'b0000, 64'h0, 168'h0, 107'h0, 71'h0, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_regs.md
# pipeline_stage_regs

Parametrised set of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the five-stage RISC-V core. Each stage has its own width and valid bit, per-stage hold (stall) and flush (bubble) control with upstream stall propagation, and saturating stall/bubble event counters. It sits between the datapath stages and the hazard/branch unit, which drives the hold and flush vectors.

## Interface
- IF_ID_W, 64, IF/ID payload width ({PC, instruction})
- ID_EX_W, 168, ID/EX payload width
- EX_MEM_W, 107, EX/MEM payload width
- MEM_WB_W, 71, MEM/WB payload width
- CNT_W, 16, width of each event counter
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- if_id_in  in  IF_ID_W  payload entering IF/ID
- if_valid  in  1  fetch stage presents a real instruction
- id_ex_in / ex_mem_in / mem_wb_in  in  ID_EX_W / EX_MEM_W / MEM_WB_W  payloads entering the later registers
- hold  in  4  per-register hold request; bit 0 = IF/ID … bit 3 = MEM/WB
- flush  in  4  per-register flush request, same indexing
- cnt_clr  in  1  synchronous clear of both counters
- if_id_out / id_ex_out / ex_mem_out / mem_wb_out  out  matching widths  registered payloads
- valid_out  out  4  valid bit of each register, same indexing
- stall_cnt  out  CNT_W  cycles with any effective hold
- bubble_cnt  out  CNT_W  bubbles inserted (stall- or flush-induced)

## Operation
- Register i loads stage input i; valid of register 0 comes from if_valid; valid of register i>0 comes from valid_out[i-1].
- Effective hold: eh[i] = hold[i] | eh[i+1] (eh[4] = 0). A held register propagates the stall to every upstream register.
- Priority per register each cycle: flush[i] > eh[i] > stall bubble > normal load.
  - flush[i]: payload <= 0, valid <= 0, regardless of hold.
  - eh[i] and not flush[i]: payload and valid unchanged.
  - eh[i-1] = 1 and eh[i] = 0 (i>0): bubble, payload <= 0, valid <= 0, because upstream data is frozen.
  - otherwise: load input payload and propagated valid.
- Register 0 never receives a stall bubble; it only holds, flushes or loads.
- stall_cnt increments in each cycle with |eh = 1 (equivalently hold != 0).
- bubble_cnt increments by 1 in each cycle where at least one register receives a bubble (flush or stall-induced) whose previous valid was 1 or whose input valid would have been 1. It counts cycles, not registers.
- Counters saturate at 2^CNT_W-1 and do not wrap. cnt_clr has priority over increment, and both counters read 0 on the following cycle.
- Payload values of invalid entries are always 0, so downstream write enables gated by valid are safe.

## Timing
- Reset low: all payloads 0, valid_out = 4'b0000, both counters 0, asynchronously. Release is sampled on the next rising edge, and the first load occurs on the first edge with reset high.
- Latency: one cycle per register. An instruction presented with if_valid at edge n appears on mem_wb_out after edge n+3 when there are no holds or flushes.
- hold/flush are sampled at the same edge as the data. Their effect is visible on the outputs in the cycle after that edge.
- Simultaneous hold[i] and flush[i]: flush wins, and the upstream registers remain held.
- Simultaneous hold[2] and flush[0]: register 0 flushes, registers 1–2 hold, and register 3 gets a bubble.
- All-ones hold: the whole pipe freezes, no bubbles are inserted, and stall_cnt increments.
- Reset asserted mid-stall: state clears immediately, and counters restart from 0.

## Test plan
- Reset/flow: reset low for 2 cycles with nonzero inputs -> all outputs 0. Release, then feed if_id_in = 64'h0000_0004_0000_0013 with if_valid = 1 -> value on if_id_out after 1 edge, valid_out = 4'b0001. With id_ex_in = 168'hA5 driven, it follows to id_ex_out one edge later.
- Load-use stall: hold = 4'b0001 for 1 cycle -> IF/ID unchanged, ID/EX payload 0 with valid_out[1] = 0, stall_cnt = 1, bubble_cnt = 1.
- Branch flush: flush = 4'b0011 while valid_out = 4'b1111 -> next cycle valid_out = 4'b1100, if_id_out = 0, id_ex_out = 0.
- Flush beats hold: hold = 4'b0100 with flush = 4'b0100 -> EX/MEM = 0, IF/ID and ID/EX unchanged, MEM/WB gets a bubble.
- Saturation: CNT_W = 4, hold = 4'b1000 for 20 cycles -> stall_cnt = 4'hF. cnt_clr pulse -> stall_cnt = 0 next cycle. A simultaneous hold does not increment in the clear cycle.
- Async reset mid-stall: reset driven low between edges during hold = 4'b1111 -> outputs and counters are 0 before the next edge.
